// File: rtl/gpio_ctrl.sv
// Per-pin padframe controller: serial shadow/active config, input sync,
// rising-edge pending bits with a combined interrupt, and loopback.
module gpio_ctrl #(
    parameter int NUM_IO      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_data_in,
    input  logic              cfg_shift,
    input  logic              cfg_load,
    output logic              cfg_data_out,
    input  logic [NUM_IO-1:0] core_out,
    input  logic [NUM_IO-1:0] core_oeb,
    output logic [NUM_IO-1:0] core_in,
    input  logic [NUM_IO-1:0] pad_in,
    output logic [NUM_IO-1:0] pad_out,
    output logic [NUM_IO-1:0] pad_oeb,
    input  logic [NUM_IO-1:0] irq_clear,
    output logic              irq
);

    localparam int CW = 3 * NUM_IO;

    localparam logic [1:0] M_IN   = 2'b01;
    localparam logic [1:0] M_OUT  = 2'b10;
    localparam logic [1:0] M_LOOP = 2'b11;

    logic [CW-1:0] r_shadow;
    logic [CW-1:0] r_active;

    logic [SYNC_STAGES-1:0][NUM_IO-1:0] r_sync;

    logic [NUM_IO-1:0] r_prev;
    logic [NUM_IO-1:0] r_loop;
    logic [NUM_IO-1:0] r_pend;

    logic [NUM_IO-1:0] w_sync;
    logic [NUM_IO-1:0] w_irq_en;
    logic [NUM_IO-1:0] w_in_mode;
    logic [NUM_IO-1:0] w_set;

    always_comb begin
        w_sync    = r_sync[SYNC_STAGES-1];
        pad_out   = '0;
        pad_oeb   = '1;
        core_in   = '0;
        w_irq_en  = '0;
        w_in_mode = '0;
        for (int i = 0; i < NUM_IO; i++) begin
            w_irq_en[i] = r_active[3*i+2];
            case (r_active[3*i +: 2])
                M_IN: begin
                    core_in[i]   = w_sync[i];
                    w_in_mode[i] = 1'b1;
                end
                M_OUT: begin
                    pad_out[i] = core_out[i];
                    pad_oeb[i] = core_oeb[i];
                    core_in[i] = w_sync[i];
                end
                M_LOOP: core_in[i] = r_loop[i];
                default: ;
            endcase
        end
    end

    // Only input-mode pins with irq_en may raise a pending bit
    assign w_set = w_sync & ~r_prev & w_in_mode & w_irq_en;

    assign irq          = |(r_pend & w_irq_en);
    assign cfg_data_out = r_shadow[CW-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow <= '0;
            r_active <= '0;
            r_sync   <= '0;
            r_prev   <= '0;
            r_loop   <= '0;
            r_pend   <= '0;
        end else begin
            if (cfg_shift)
                r_shadow <= {r_shadow[CW-2:0], cfg_data_in};
            if (cfg_load)
                r_active <= r_shadow;
            r_sync[0] <= pad_in;
            for (int s = 1; s < SYNC_STAGES; s++)
                r_sync[s] <= r_sync[s-1];
            r_prev <= w_sync;
            r_loop <= core_out;
            r_pend <= (r_pend & ~irq_clear) | w_set;
        end
    end

endmodule
